// File: rtl/byte_deser.sv
`default_nettype none
// ============================================================================
// byte_deser : 8N1 serial-to-byte deserializer with framing-error detection
// Revision   : 1.0
// ============================================================================
module byte_deser #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sin,
    output logic [7:0] c,
    output logic       enb,
    output logic       ferr,
    output logic       busy
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] ONE  = TW'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]    bitcnt, bitcnt_n;
    logic [7:0]    shreg, shreg_n;
    logic [7:0]    c_n;
    logic          enb_n, ferr_n;
    logic          sync1, sin_s;

    // Synchronizer flops reset to 1 so a reset looks like an idle line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            sin_s <= 1'b1;
        end else begin
            sync1 <= sin;
            sin_s <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            timer  <= '0;
            bitcnt <= '0;
            shreg  <= '0;
            c      <= '0;
            enb    <= 1'b0;
            ferr   <= 1'b0;
        end else begin
            state  <= state_n;
            timer  <= timer_n;
            bitcnt <= bitcnt_n;
            shreg  <= shreg_n;
            c      <= c_n;
            enb    <= enb_n;
            ferr   <= ferr_n;
        end
    end

    always_comb begin
        state_n  = state;
        timer_n  = timer + ONE;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        c_n      = c;
        enb_n    = 1'b0;
        ferr_n   = 1'b0;

        unique case (state)
            IDLE: begin
                timer_n = '0;
                if (!sin_s) begin
                    state_n = START;
                end
            end
            START: begin
                // Mid-start-bit check rejects short glitches on the line.
                if (timer == HALF) begin
                    timer_n  = '0;
                    bitcnt_n = '0;
                    state_n  = sin_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (timer == FULL) begin
                    shreg_n[bitcnt] = sin_s;
                    timer_n         = '0;
                    bitcnt_n        = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
                        state_n = STOP;
                    end
                end
            end
            STOP: begin
                if (timer == FULL) begin
                    timer_n = '0;
                    if (sin_s) begin
                        c_n     = shreg;
                        enb_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // A broken frame leaves the line low; only a high line re-arms.
                timer_n = '0;
                if (sin_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                timer_n = '0;
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_byte_deser.sv
`default_nettype none
// ============================================================================
// tb_byte_deser : directed self-checking bench for byte_deser (16 and 4 clk/bit)
// Revision      : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_byte_deser;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sin16 = 1'b1;
    logic       sin4  = 1'b1;
    logic [7:0] c16, c4;
    logic       enb16, ferr16, busy16;
    logic       enb4, ferr4, busy4;

    int tests_run = 0;
    int tests_failed = 0;

    int         cyc = 0;
    int         enb16_cnt = 0, ferr16_cnt = 0, enb4_cnt = 0, ferr4_cnt = 0;
    int         viol = 0;
    logic [7:0] prev_c16 = 8'h00, prev_c4 = 8'h00;
    int         enb16_cyc[$];
    logic [7:0] enb16_c[$];
    logic [7:0] enb4_c[$];

    byte_deser #(.CLKS_PER_BIT(16)) dut16 (
        .clk(clk), .rst(rst), .sin(sin16),
        .c(c16), .enb(enb16), .ferr(ferr16), .busy(busy16)
    );

    byte_deser #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst(rst), .sin(sin4),
        .c(c4), .enb(enb4), .ferr(ferr4), .busy(busy4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder and invariant watch, sampled away from the active edge.
    always @(negedge clk) begin
        if (enb16) begin
            enb16_cnt = enb16_cnt + 1;
            enb16_cyc.push_back(cyc);
            enb16_c.push_back(c16);
        end
        if (ferr16) ferr16_cnt = ferr16_cnt + 1;
        if (enb4) begin
            enb4_cnt = enb4_cnt + 1;
            enb4_c.push_back(c4);
        end
        if (ferr4) ferr4_cnt = ferr4_cnt + 1;
        if (enb16 && ferr16) viol = viol + 1;
        if (enb4 && ferr4) viol = viol + 1;
        if (rst && c16 != prev_c16 && !enb16) viol = viol + 1;
        if (rst && c4 != prev_c4 && !enb4) viol = viol + 1;
        prev_c16 = c16;
        prev_c4  = c4;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input int sel, input logic v, input int n);
        if (sel == 16) sin16 = v;
        else           sin4  = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int sel, input logic [7:0] d, input logic stop);
        drive_bit(sel, 1'b0, sel);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i], sel);
        drive_bit(sel, stop, sel);
    endtask

    int e0, f0;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_c",    {24'd0, c16}, 32'h00);
        check("reset_enb",  {31'd0, enb16}, 32'd0);
        check("reset_ferr", {31'd0, ferr16}, 32'd0);
        check("reset_busy", {31'd0, busy16}, 32'd0);
        #2 rst = 1'b1;
        repeat (5) @(negedge clk);

        // Single good frame 0xA5
        send(16, 8'hA5, 1'b1);
        drive_bit(16, 1'b1, 20);
        check("a5_enb_count", enb16_cnt, 1);
        check("a5_c_at_enb",  {24'd0, enb16_c[0]}, 32'hA5);
        check("a5_ferr",      ferr16_cnt, 0);
        check("a5_busy_after", {31'd0, busy16}, 32'd0);

        // 3-cycle glitch rejected
        drive_bit(16, 1'b0, 3);
        drive_bit(16, 1'b1, 30);
        check("glitch_enb",  enb16_cnt, 1);
        check("glitch_ferr", ferr16_cnt, 0);
        check("glitch_busy", {31'd0, busy16}, 32'd0);
        check("glitch_c",    {24'd0, c16}, 32'hA5);

        // Good 0x3C, then 0x81 with bad stop, held low 40 cycles
        send(16, 8'h3C, 1'b1);
        drive_bit(16, 1'b1, 10);
        check("3c_c", {24'd0, c16}, 32'h3C);
        e0 = enb16_cnt;
        send(16, 8'h81, 1'b0);
        drive_bit(16, 1'b0, 40);
        check("ferr_count",    ferr16_cnt, 1);
        check("ferr_no_enb",   enb16_cnt, e0);
        check("ferr_c_kept",   {24'd0, c16}, 32'h3C);
        check("wait_high_busy", {31'd0, busy16}, 32'd1);
        drive_bit(16, 1'b1, 10);
        check("wait_high_exit", {31'd0, busy16}, 32'd0);
        send(16, 8'h55, 1'b1);
        drive_bit(16, 1'b1, 10);
        check("55_enb", enb16_cnt, e0 + 1);
        check("55_c",   {24'd0, c16}, 32'h55);

        // Back-to-back 0x00, 0xFF with zero idle
        e0 = enb16_cnt;
        send(16, 8'h00, 1'b1);
        send(16, 8'hFF, 1'b1);
        drive_bit(16, 1'b1, 10);
        check("b2b_enb_count", enb16_cnt, e0 + 2);
        check("b2b_c0", {24'd0, enb16_c[e0]},   32'h00);
        check("b2b_c1", {24'd0, enb16_c[e0+1]}, 32'hFF);
        check("b2b_spacing", enb16_cyc[e0+1] - enb16_cyc[e0], 160);

        // Reset pulse during data bit 4
        e0 = enb16_cnt;
        f0 = ferr16_cnt;
        drive_bit(16, 1'b0, 16);
        for (int i = 0; i < 4; i++) drive_bit(16, 1'b1, 16);
        drive_bit(16, 1'b0, 8);
        #2 rst = 1'b0;
        sin16 = 1'b1;
        #1;
        check("rst_c",    {24'd0, c16},   32'h00);
        check("rst_busy", {31'd0, busy16}, 32'd0);
        check("rst_enb",  {31'd0, enb16},  32'd0);
        check("rst_ferr", {31'd0, ferr16}, 32'd0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_no_enb",  enb16_cnt, e0);
        check("rst_no_ferr", ferr16_cnt, f0);
        send(16, 8'h5A, 1'b1);
        drive_bit(16, 1'b1, 10);
        check("5a_enb", enb16_cnt, e0 + 1);
        check("5a_c",   {24'd0, c16}, 32'h5A);

        // Minimum bit period
        send(4, 8'hC3, 1'b1);
        drive_bit(4, 1'b1, 12);
        check("cpb4_enb",  enb4_cnt, 1);
        check("cpb4_c",    {24'd0, enb4_c[0]}, 32'hC3);
        check("cpb4_ferr", ferr4_cnt, 0);
        check("cpb4_busy", {31'd0, busy4}, 32'd0);

        check("invariants", viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
